// File: rtl/conv_seq_ctrl.sv
// Sequencer for the convolution datapath: per output position it walks NUM_CH channels
// (address, window load, KSIZE MAC rows), then stores, advances counters and checks for run end.
module conv_seq_ctrl #(
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned NUM_POS = 16,
  parameter int unsigned SEL_W   = $clog2(KSIZE + 1),
  parameter int unsigned CH_W    = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_done,
  input  logic             store_ready,
  output logic             addr_gen,
  output logic             flush_acc,
  output logic             load,
  output logic [SEL_W-1:0] mux_sel,
  output logic             add,
  output logic             acc_enable,
  output logic             store,
  output logic             counter_enable,
  output logic [CH_W-1:0]  ch_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned ROW_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned POS_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KSIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_POS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LOAD   = 3'd2,
    S_MAC    = 3'd3,
    S_STORE  = 3'd4,
    S_UPDATE = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic             addr_gen_q, addr_gen_d;
  logic             flush_acc_q, flush_acc_d;
  logic             load_q, load_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic             add_q, add_d;
  logic             acc_enable_q, acc_enable_d;
  logic             store_q, store_d;
  logic             counter_enable_q, counter_enable_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state and counters; outputs are decoded from the next state so the
  // output flops always track the state register exactly.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ch_d    = ch_q;
    pos_d   = pos_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          row_d   = '0;
          ch_d    = '0;
          pos_d   = '0;
        end
      end
      S_ADDR: state_d = S_LOAD;
      S_LOAD: begin
        if (load_done) begin
          state_d = S_MAC;
          row_d   = '0;
        end
      end
      S_MAC: begin
        if (row_q != ROW_LAST) begin
          row_d = row_q + ROW_W'(1);
        end else begin
          row_d = '0;
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_ADDR;
          end else begin
            ch_d    = '0;
            state_d = S_STORE;
          end
        end
      end
      S_STORE: begin
        if (store_ready) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_CHECK;
      S_CHECK: begin
        if (pos_q == POS_LAST) begin
          state_d = S_DONE;
        end else begin
          pos_d   = pos_q + POS_W'(1);
          state_d = S_ADDR;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        row_d   = '0;
        ch_d    = '0;
        pos_d   = '0;
      end
    endcase

    addr_gen_d       = (state_d == S_ADDR);
    flush_acc_d      = (state_d == S_ADDR) && (ch_d == '0);
    load_d           = (state_d == S_LOAD);
    mux_sel_d        = (state_d == S_MAC) ? (SEL_W'(row_d) + SEL_W'(1)) : '0;
    add_d            = (state_d == S_MAC);
    acc_enable_d     = (state_d == S_MAC);
    store_d          = (state_d == S_STORE);
    counter_enable_d = (state_d == S_UPDATE);
    ch_idx_d         = ch_d;
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      row_q            <= '0;
      ch_q             <= '0;
      pos_q            <= '0;
      addr_gen_q       <= 1'b0;
      flush_acc_q      <= 1'b0;
      load_q           <= 1'b0;
      mux_sel_q        <= '0;
      add_q            <= 1'b0;
      acc_enable_q     <= 1'b0;
      store_q          <= 1'b0;
      counter_enable_q <= 1'b0;
      ch_idx_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      row_q            <= row_d;
      ch_q             <= ch_d;
      pos_q            <= pos_d;
      addr_gen_q       <= addr_gen_d;
      flush_acc_q      <= flush_acc_d;
      load_q           <= load_d;
      mux_sel_q        <= mux_sel_d;
      add_q            <= add_d;
      acc_enable_q     <= acc_enable_d;
      store_q          <= store_d;
      counter_enable_q <= counter_enable_d;
      ch_idx_q         <= ch_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign addr_gen       = addr_gen_q;
  assign flush_acc      = flush_acc_q;
  assign load           = load_q;
  assign mux_sel        = mux_sel_q;
  assign add            = add_q;
  assign acc_enable     = acc_enable_q;
  assign store          = store_q;
  assign counter_enable = counter_enable_q;
  assign ch_idx         = ch_idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: three configurations driven by a procedural loop model
// (positions x channels x rows) with random load/store latencies and start behaviour.
module tb_conv_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic       load_done;
  logic       store_ready;

  int vectors;
  int miscompares;
  int cyc;
  int done_cnt, done_cyc, acc_cnt, ld_cnt, st_cnt, ce_cnt;

  // u0: defaults (KSIZE=3, NUM_CH=1, NUM_POS=16)
  logic       ag0, fl0, ld0, ad0, ac0, st0, ce0, bz0, dn0;
  logic [1:0] ms0;
  logic [0:0] ch0;
  // u1: KSIZE=3, NUM_CH=3, NUM_POS=2
  logic       ag1, fl1, ld1, ad1, ac1, st1, ce1, bz1, dn1;
  logic [1:0] ms1;
  logic [1:0] ch1;
  // u2: KSIZE=1, NUM_CH=1, NUM_POS=1
  logic       ag2, fl2, ld2, ad2, ac2, st2, ce2, bz2, dn2;
  logic [0:0] ms2;
  logic [0:0] ch2;

  conv_seq_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .load_done(load_done), .store_ready(store_ready),
    .addr_gen(ag0), .flush_acc(fl0), .load(ld0), .mux_sel(ms0), .add(ad0), .acc_enable(ac0),
    .store(st0), .counter_enable(ce0), .ch_idx(ch0), .busy(bz0), .done(dn0)
  );

  conv_seq_ctrl #(.KSIZE(3), .NUM_CH(3), .NUM_POS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .load_done(load_done), .store_ready(store_ready),
    .addr_gen(ag1), .flush_acc(fl1), .load(ld1), .mux_sel(ms1), .add(ad1), .acc_enable(ac1),
    .store(st1), .counter_enable(ce1), .ch_idx(ch1), .busy(bz1), .done(dn1)
  );

  conv_seq_ctrl #(.KSIZE(1), .NUM_CH(1), .NUM_POS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .load_done(load_done), .store_ready(store_ready),
    .addr_gen(ag2), .flush_acc(fl2), .load(ld2), .mux_sel(ms2), .add(ad2), .acc_enable(ac2),
    .store(st2), .counter_enable(ce2), .ch_idx(ch2), .busy(bz2), .done(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {addr_gen, flush, load, mux[3:0], add, acc, store, cen, ch[1:0], busy, done}
  function automatic logic [14:0] obs(input int id);
    case (id)
      0:       return {ag0, fl0, ld0, 4'(ms0), ad0, ac0, st0, ce0, 2'(ch0), bz0, dn0};
      1:       return {ag1, fl1, ld1, 4'(ms1), ad1, ac1, st1, ce1, 2'(ch1), bz1, dn1};
      default: return {ag2, fl2, ld2, 4'(ms2), ad2, ac2, st2, ce2, 2'(ch2), bz2, dn2};
    endcase
  endfunction

  function automatic logic [14:0] mk(input bit ag, input bit fl, input bit ld, input int mux,
                                     input bit ad, input bit ac, input bit st, input bit ce,
                                     input int ch, input bit bz, input bit dn);
    return {ag, fl, ld, 4'(mux), ad, ac, st, ce, 2'(ch), bz, dn};
  endfunction

  function automatic bit rb(input bit tie);
    return tie ? 1'b1 : 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One cycle: check outputs of the current state, then drive inputs for the next edge.
  task automatic step(input int id, input logic [14:0] e, input string tag,
                      input logic ld, input logic sr, input logic st);
    logic [14:0] o;
    @(negedge clk);
    o = obs(id);
    chk(tag, 32'(o), 32'(e));
    cyc++;
    if (o[0])  begin done_cnt++; done_cyc = cyc; end
    if (o[6])  acc_cnt++;
    if (o[12]) ld_cnt++;
    if (o[5])  st_cnt++;
    if (o[4])  ce_cnt++;
    load_done   = ld;
    store_ready = sr;
    start_v     = 3'(st) << id;
  endtask

  task automatic run(input int id, input int k, input int nch, input int npos,
                     input int lw_lo, input int lw_hi, input int sw_lo, input int sw_hi,
                     input bit hold);
    int  t0, dc0, ce0, waits, lw, sw, acc0, ldc0, stc0;
    bit  tie;
    logic sx;
    tie   = (lw_hi == 0) && (sw_hi == 0);
    dc0   = done_cnt;
    ce0   = ce_cnt;
    waits = 0;
    step(id, '0, $sformatf("u%0d idle", id), rb(tie), rb(tie), 1'b1);
    t0 = cyc;
    for (int p = 0; p < npos; p++) begin
      acc0 = acc_cnt;
      for (int c = 0; c < nch; c++) begin
        sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
        step(id, mk(1, c == 0, 0, 0, 0, 0, 0, 0, c, 1, 0),
             $sformatf("u%0d addr p%0d c%0d", id, p, c), rb(tie), rb(tie), sx);
        lw = int'($urandom_range(lw_hi, lw_lo));
        waits += lw;
        ldc0 = ld_cnt;
        for (int i = 0; i <= lw; i++) begin
          sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
          step(id, mk(0, 0, 1, 0, 0, 0, 0, 0, c, 1, 0),
               $sformatf("u%0d load p%0d c%0d w%0d", id, p, c, i), (i == lw), rb(tie), sx);
        end
        chk($sformatf("u%0d load_held p%0d", id, p), 32'(ld_cnt - ldc0), 32'(lw + 1));
        for (int r = 0; r < k; r++) begin
          sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
          step(id, mk(0, 0, 0, r + 1, 1, 1, 0, 0, c, 1, 0),
               $sformatf("u%0d mac p%0d c%0d r%0d", id, p, c, r), rb(tie), rb(tie), sx);
        end
      end
      chk($sformatf("u%0d acc_per_store p%0d", id, p), 32'(acc_cnt - acc0), 32'(nch * k));
      sw = int'($urandom_range(sw_hi, sw_lo));
      waits += sw;
      stc0 = st_cnt;
      for (int i = 0; i <= sw; i++) begin
        sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
        step(id, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),
             $sformatf("u%0d store p%0d w%0d", id, p, i), rb(tie), (i == sw), sx);
      end
      chk($sformatf("u%0d store_held p%0d", id, p), 32'(st_cnt - stc0), 32'(sw + 1));
      sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
      step(id, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), $sformatf("u%0d update p%0d", id, p),
           rb(tie), rb(tie), sx);
      step(id, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), $sformatf("u%0d check p%0d", id, p),
           rb(tie), rb(tie), sx);
    end
    sx = hold ? 1'b1 : (tie ? 1'b0 : rb(1'b0));
    step(id, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), $sformatf("u%0d done", id),
         rb(tie), rb(tie), sx);
    chk($sformatf("u%0d run_len", id), 32'(done_cyc - t0),
        32'(npos * (nch * (2 + k) + 3) + 1 + waits));
    chk($sformatf("u%0d done_pulses", id), 32'(done_cnt - dc0), 32'd1);
    chk($sformatf("u%0d cen_per_run", id), 32'(ce_cnt - ce0), 32'(npos));
  endtask

  task automatic idle_cycles(input int id, input int n);
    for (int i = 0; i < n; i++)
      step(id, '0, $sformatf("u%0d idle_wait", id), rb(1'b0), rb(1'b0), 1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    done_cnt = 0; done_cyc = 0; acc_cnt = 0; ld_cnt = 0; st_cnt = 0; ce_cnt = 0;
    rst_n = 1'b0; start_v = '0; load_done = 1'b0; store_ready = 1'b0;
    #1;
    for (int id = 0; id < 3; id++) chk($sformatf("u%0d reset", id), 32'(obs(id)), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults, zero wait: 8 cycles/position, done 129 cycles after start
    run(0, 3, 1, 16, 0, 0, 0, 0, 1'b0);
    idle_cycles(0, 2);
    // Multi-channel accumulation
    run(1, 3, 3, 2, 0, 0, 0, 0, 1'b0);
    idle_cycles(1, 1);
    // Load delayed 4 cycles, store delayed 6 cycles
    run(0, 3, 1, 16, 4, 4, 0, 0, 1'b0);
    run(0, 3, 1, 16, 0, 0, 6, 6, 1'b0);
    // Random latencies
    run(1, 3, 3, 2, 0, 3, 0, 3, 1'b0);
    run(1, 3, 3, 2, 0, 5, 0, 2, 1'b0);
    run(2, 1, 1, 1, 0, 3, 0, 3, 1'b0);
    idle_cycles(2, 3);
    // Start held high: back-to-back runs
    run(0, 3, 1, 16, 0, 2, 0, 2, 1'b1);
    run(0, 3, 1, 16, 0, 2, 0, 2, 1'b1);
    run(2, 1, 1, 1, 0, 1, 0, 1, 1'b1);
    run(2, 1, 1, 1, 0, 1, 0, 1, 1'b1);
    run(2, 1, 1, 1, 0, 0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of MAC, then a full run from position 0
    idle_cycles(0, 1);
    step(0, '0, "rst idle", 1'b0, 1'b0, 1'b1);
    step(0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rst addr", 1'b0, 1'b0, 1'b0);
    step(0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "rst load", 1'b1, 1'b0, 1'b0);
    step(0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0), "rst mac0", 1'b0, 1'b0, 1'b0);
    step(0, mk(0, 0, 0, 2, 1, 1, 0, 0, 0, 1, 0), "rst mac1", 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs(0)), 32'd0);
    @(posedge clk);
    #1 chk("rst_held", 32'(obs(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 3, 1, 16, 0, 1, 0, 1, 1'b0);

    // Minimal configuration
    run(2, 1, 1, 1, 0, 0, 0, 0, 1'b0);
    idle_cycles(2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
